// File: rtl/arm_mc_pkg.sv
// Shared types, opcode constants, the instruction decoder and the ALU for the
// multicycle ARM-subset core.
package arm_mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_SUB = 4'b0010,
        ALU_ADD = 4'b0100,
        ALU_ORR = 4'b1100
    } alu_cmd_t;

    typedef enum logic [1:0] {
        K_DP,
        K_MEM,
        K_BR,
        K_UNDEF
    } kind_t;

    localparam logic [3:0] COND_AL   = 4'b1110;
    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [3:0] OP_BRANCH = 4'b1010;
    localparam logic [3:0] REG_PC    = 4'd15;

    typedef struct packed {
        kind_t      kind;
        logic [3:0] rn;
        logic [3:0] rd;
        logic [3:0] rm;
        logic [31:0] imm;    // rotated imm8, zero-extended imm12 or scaled branch offset
        logic       immOp;   // DP second operand comes from imm
        logic       load;    // MEM: 1 = LDR, 0 = STR
        alu_cmd_t   cmd;     // ALU operation used in EXEC
    } decode_t;

    function automatic decode_t decodeInstr(input logic [31:0] ir);
        decode_t    d;
        logic [4:0]  rotAmt;
        logic [63:0] rotDbl;
        d.kind  = K_UNDEF;
        d.rn    = ir[19:16];
        d.rd    = ir[15:12];
        d.rm    = ir[3:0];
        d.imm   = '0;
        d.immOp = ir[25];
        d.load  = ir[20];
        d.cmd   = ALU_ADD;
        rotAmt  = {ir[11:8], 1'b0};
        rotDbl  = {24'd0, ir[7:0], 24'd0, ir[7:0]} >> rotAmt;
        if (ir[27:26] == OP_DP) begin
            d.imm = rotDbl[31:0];
            // S=1 and a non-zero register shift field are outside the subset
            if (!ir[20] && (ir[25] || ir[11:4] == 8'd0)) begin
                case (ir[24:21])
                    4'b0000: begin d.kind = K_DP; d.cmd = ALU_AND; end
                    4'b0010: begin d.kind = K_DP; d.cmd = ALU_SUB; end
                    4'b0100: begin d.kind = K_DP; d.cmd = ALU_ADD; end
                    4'b1100: begin d.kind = K_DP; d.cmd = ALU_ORR; end
                    default: d.kind = K_UNDEF;
                endcase
            end
        end else if (ir[27:26] == OP_MEM) begin
            d.imm = {20'd0, ir[11:0]};
            d.cmd = ir[23] ? ALU_ADD : ALU_SUB;
            if (!ir[25] && ir[24] && !ir[22] && !ir[21]) begin
                d.kind = K_MEM;
            end
        end else if (ir[27:24] == OP_BRANCH) begin
            d.kind = K_BR;
            d.imm  = {{6{ir[23]}}, ir[23:0], 2'b00};
            d.cmd  = ALU_ADD;
        end
        return d;
    endfunction

    function automatic logic [31:0] aluOp(input alu_cmd_t cmd, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [31:0] r;
        case (cmd)
            ALU_AND: r = x & y;
            ALU_SUB: r = x - y;
            ALU_ADD: r = x + y;
            ALU_ORR: r = x | y;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arm_multicycle_core_if.sv
// Unified instruction/data memory port with a req/ready handshake.
interface arm_multicycle_core_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mc_regfile.sv
// General registers R0-R14: two combinational read ports, one synchronous write
// port. R15 is not stored here; reads of index 15 return 0 and the core muxes PC.
module mc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rdAddrA,
    input  logic [3:0]  rdAddrB,
    output logic [31:0] rdDataA,
    output logic [31:0] rdDataB,
    input  logic        wrEn,
    input  logic [3:0]  wrAddr,
    input  logic [31:0] wrData
);
    import arm_mc_pkg::*;

    logic [31:0] regs [0:14];

    // Clear all registers on reset, otherwise perform the single write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn && wrAddr != REG_PC) begin
            regs[wrAddr] <= wrData;
        end
    end

    assign rdDataA = (rdAddrA == REG_PC) ? '0 : regs[rdAddrA];
    assign rdDataB = (rdAddrB == REG_PC) ? '0 : regs[rdAddrB];

endmodule

// File: rtl/arm_multicycle_core.sv
// Multicycle ARM-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over one
// shared ALU and one unified memory port.
module arm_multicycle_core #(
    parameter logic [31:0] RESET_PC      = 32'h0,
    parameter int          ADDR_W        = 32,
    parameter bit          HALT_ON_UNDEF = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    arm_multicycle_core_if.master        memBus,
    output logic                         halted,
    output logic                         retire,
    output logic [31:0]                  pc_dbg
);
    import arm_mc_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] regA;
    logic [31:0] regB;
    logic [31:0] aluOut;
    logic [31:0] mdr;

    decode_t     dec;
    logic        condPass;
    logic [31:0] pcPlus4;
    logic [31:0] pcPlus8;
    logic [3:0]  rdAddrB;
    logic [31:0] rfDataA;
    logic [31:0] rfDataB;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] aluX;
    logic [31:0] aluY;
    logic [31:0] aluRes;
    logic [31:0] wbData;
    logic [31:0] addrFull;
    logic        rfWe;

    assign dec      = decodeInstr(ir);
    assign condPass = (ir[31:28] == COND_AL);
    assign pcPlus4  = pc + 32'd4;
    assign pcPlus8  = pc + 32'd8;

    // STR reads its data register through port B instead of Rm
    assign rdAddrB = (dec.kind == K_MEM) ? dec.rd : dec.rm;
    assign opA     = (dec.rn == REG_PC) ? pcPlus8 : rfDataA;
    assign opB     = (rdAddrB == REG_PC) ? pcPlus8 : rfDataB;

    assign aluX   = (dec.kind == K_BR) ? pcPlus8 : regA;
    assign aluY   = (dec.kind == K_DP && !dec.immOp) ? regB : dec.imm;
    assign aluRes = aluOp(dec.cmd, aluX, aluY);
    assign wbData = (dec.kind == K_MEM) ? mdr : aluOut;
    assign rfWe   = (state == S_WB) && (dec.rd != REG_PC);

    mc_regfile uRegfile (
        .clk     (clk),
        .rst     (rst),
        .rdAddrA (dec.rn),
        .rdAddrB (rdAddrB),
        .rdDataA (rfDataA),
        .rdDataB (rfDataB),
        .wrEn    (rfWe),
        .wrAddr  (dec.rd),
        .wrData  (wbData)
    );

    // Instruction sequencer and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            regA   <= '0;
            regB   <= '0;
            aluOut <= '0;
            mdr    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (memBus.ready) begin
                        ir    <= memBus.rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    regA <= opA;
                    regB <= opB;
                    if (!condPass) begin
                        pc    <= pcPlus4;
                        state <= S_FETCH;
                    end else if (dec.kind == K_UNDEF) begin
                        if (HALT_ON_UNDEF) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= pcPlus4;
                            state <= S_FETCH;
                        end
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    aluOut <= aluRes;
                    if (dec.kind == K_BR) begin
                        pc    <= aluRes;
                        state <= S_FETCH;
                    end else if (dec.kind == K_MEM) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (memBus.ready) begin
                        if (dec.load) begin
                            mdr   <= memBus.rdata;
                            state <= S_WB;
                        end else begin
                            pc    <= pcPlus4;
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    pc    <= (dec.rd == REG_PC) ? wbData : pcPlus4;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Bus outputs follow the state register; rst forces the idle values at once
    assign addrFull      = (state == S_MEM) ? aluOut : pc;
    assign memBus.req    = !rst && (state == S_FETCH || state == S_MEM);
    assign memBus.we     = !rst && (state == S_MEM) && !dec.load;
    assign memBus.addr   = addrFull[ADDR_W-1:0] & ADDR_MASK;
    assign memBus.wdata  = regB;

    assign halted = !rst && (state == S_HALT);
    assign pc_dbg = rst ? RESET_PC : pc;
    assign retire = !rst && (
                      (state == S_DECODE && (!condPass || (dec.kind == K_UNDEF && !HALT_ON_UNDEF)))
                   || (state == S_EXEC && dec.kind == K_BR)
                   || (state == S_MEM && !dec.load && memBus.ready)
                   || (state == S_WB));

endmodule

// File: tb/tb_arm_multicycle_core.sv
// Directed bench for arm_multicycle_core with a small wait-state memory model.
module tb_arm_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halted;
    logic        retire;
    logic [31:0] pcDbg;

    arm_multicycle_core_if #(.ADDR_W(32)) bus ();

    arm_multicycle_core #(
        .RESET_PC      (32'h0),
        .ADDR_W        (32),
        .HALT_ON_UNDEF (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .memBus (bus),
        .halted (halted),
        .retire (retire),
        .pc_dbg (pcDbg)
    );

    always #5 clk = ~clk;

    // Memory model: 64 words, reads of one address can be delayed
    logic [31:0] mem [0:63];
    logic [31:0] delayAddr = 32'hFFFF_FFFF;
    int unsigned delayCycles = 0;
    int unsigned waitCnt = 0;
    logic        memReady;

    always_comb begin
        memReady = 1'b0;
        if (bus.req) begin
            memReady = bus.we || (bus.addr != delayAddr) || (waitCnt >= delayCycles);
        end
    end

    assign bus.ready = memReady;
    assign bus.rdata = (bus.addr[31:8] == 24'd0) ? mem[bus.addr[7:2]] : 32'd0;

    // Count wait cycles of the pending request
    always @(posedge clk) begin
        if (!bus.req || bus.ready) waitCnt <= 0;
        else                       waitCnt <= waitCnt + 1;
    end

    // Log every accepted write
    int unsigned writeCount = 0;
    logic [31:0] wrAddrLog [0:15];
    logic [31:0] wrDataLog [0:15];
    always @(posedge clk) begin
        if (bus.req && bus.ready && bus.we) begin
            wrAddrLog[writeCount[3:0]] <= bus.addr;
            wrDataLog[writeCount[3:0]] <= bus.wdata;
            writeCount <= writeCount + 1;
        end
    end

    int tests = 0;
    int fails = 0;
    int cycleNo = 0;

    task automatic tick();
        @(negedge clk);
        cycleNo++;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        delayAddr   = 32'hFFFF_FFFF;
        delayCycles = 0;
    endtask

    task automatic startCpu();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cycleNo = 0;
    endtask

    task automatic waitRetire(input int limit, output int at);
        at = -1;
        for (int n = 0; n < limit && at < 0; n++) begin
            tick();
            if (retire) at = cycleNo;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus.req, bus.we, retire, halted} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: req/we/retire/halted=%b expected 0000",
                     {bus.req, bus.we, retire, halted});
        end
        tests++;
        if (pcDbg !== 32'h0) begin
            fails++;
            $display("FAIL reset_pc: pc_dbg=%h expected 00000000", pcDbg);
        end
    endtask

    task automatic test_ldr_zero_wait();
        int at;
        int unsigned base;
        clearMem();
        mem[0] = 32'hE590_1008;   // LDR R1,[R0,#8]
        mem[1] = 32'hE580_1040;   // STR R1,[R0,#0x40]
        mem[2] = 32'hDEAD_BEEF;
        startCpu();
        base = writeCount;
        tick();
        tests++;
        if ({bus.req, bus.addr, pcDbg} !== {1'b1, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL first_fetch: req=%b addr=%h pc=%h expected 1 00000000 00000000",
                     bus.req, bus.addr, pcDbg);
        end
        waitRetire(20, at);
        tests++;
        if (at != 5) begin
            fails++;
            $display("FAIL ldr_latency: retire cycle %0d expected 5", at);
        end
        tick();
        tests++;
        if ({bus.req, bus.we, bus.addr} !== {1'b1, 1'b0, 32'h4}) begin
            fails++;
            $display("FAIL ldr_next_fetch: req=%b we=%b addr=%h expected 1 0 00000004",
                     bus.req, bus.we, bus.addr);
        end
        waitRetire(20, at);
        tick();
        tests++;
        if (writeCount - base != 1 || wrAddrLog[base[3:0]] !== 32'h40
            || wrDataLog[base[3:0]] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL ldr_value: writes=%0d addr=%h data=%h expected 1 00000040 deadbeef",
                     writeCount - base, wrAddrLog[base[3:0]], wrDataLog[base[3:0]]);
        end
    endtask

    task automatic test_ldr_wait_states();
        int at;
        clearMem();
        mem[0] = 32'hE590_1008;
        mem[2] = 32'hDEAD_BEEF;
        delayAddr   = 32'h0;
        delayCycles = 3;
        startCpu();
        for (int c = 1; c <= 4; c++) begin
            tick();
            tests++;
            if ({bus.req, bus.we, bus.addr} !== {1'b1, 1'b0, 32'h0}) begin
                fails++;
                $display("FAIL fetch_hold c%0d: req=%b we=%b addr=%h expected 1 0 00000000",
                         c, bus.req, bus.we, bus.addr);
            end
        end
        waitRetire(20, at);
        tests++;
        if (at != 8) begin
            fails++;
            $display("FAIL ldr_wait_latency: retire cycle %0d expected 8", at);
        end
    endtask

    task automatic test_dp();
        int at;
        int unsigned base;
        int expAt [0:4];
        expAt = '{4, 8, 12, 16, 20};
        clearMem();
        mem[0] = 32'hE280_1011;   // ADD R1,R0,#0x11
        mem[1] = 32'hE281_24FF;   // ADD R2,R1,#0xFF000000
        mem[2] = 32'hE042_3002;   // SUB R3,R2,R2
        mem[3] = 32'hE580_2040;   // STR R2,[R0,#0x40]
        mem[4] = 32'hE580_3044;   // STR R3,[R0,#0x44]
        startCpu();
        base = writeCount;
        for (int k = 0; k < 5; k++) begin
            waitRetire(20, at);
            tests++;
            if (at != expAt[k]) begin
                fails++;
                $display("FAIL dp_retire%0d: cycle %0d expected %0d", k, at, expAt[k]);
            end
        end
        tick();
        tests++;
        if (writeCount - base != 2 || wrAddrLog[base[3:0]] !== 32'h40
            || wrDataLog[base[3:0]] !== 32'hFF00_0011) begin
            fails++;
            $display("FAIL dp_add_imm_rot: writes=%0d addr=%h data=%h expected 2 00000040 ff000011",
                     writeCount - base, wrAddrLog[base[3:0]], wrDataLog[base[3:0]]);
        end
        tests++;
        if (wrAddrLog[base[3:0] + 4'd1] !== 32'h44 || wrDataLog[base[3:0] + 4'd1] !== 32'h0) begin
            fails++;
            $display("FAIL dp_sub_reg: addr=%h data=%h expected 00000044 00000000",
                     wrAddrLog[base[3:0] + 4'd1], wrDataLog[base[3:0] + 4'd1]);
        end
    endtask

    task automatic test_str();
        int at;
        int unsigned base;
        clearMem();
        mem[0] = 32'hE280_0C01;   // ADD R0,R0,#0x100
        mem[1] = 32'hE280_2055;   // ADD R2,R0,#0x55
        mem[2] = 32'hE500_2004;   // STR R2,[R0,#-4]
        mem[3] = 32'hE580_0000;   // STR R0,[R0]
        startCpu();
        base = writeCount;
        waitRetire(20, at);
        waitRetire(20, at);
        waitRetire(20, at);
        tests++;
        if (at != 12 || {bus.req, bus.we, bus.addr, bus.wdata} !== {1'b1, 1'b1, 32'hFC, 32'h155}) begin
            fails++;
            $display("FAIL str_bus: cycle %0d req=%b we=%b addr=%h wdata=%h expected 12 1 1 000000fc 00000155",
                     at, bus.req, bus.we, bus.addr, bus.wdata);
        end
        waitRetire(20, at);
        tick();
        tests++;
        if (writeCount - base != 2 || wrAddrLog[base[3:0]] !== 32'hFC
            || wrAddrLog[base[3:0] + 4'd1] !== 32'h100 || wrDataLog[base[3:0] + 4'd1] !== 32'h100) begin
            fails++;
            $display("FAIL str_regs_kept: writes=%0d a0=%h a1=%h d1=%h expected 2 000000fc 00000100 00000100",
                     writeCount - base, wrAddrLog[base[3:0]], wrAddrLog[base[3:0] + 4'd1],
                     wrDataLog[base[3:0] + 4'd1]);
        end
    endtask

    task automatic test_branch_loop();
        int at;
        clearMem();
        mem[0] = 32'hEA00_0006;   // B 0x20
        mem[8] = 32'hEAFF_FFFE;   // B .
        startCpu();
        waitRetire(20, at);
        tests++;
        if (at != 3) begin
            fails++;
            $display("FAIL b_latency: retire cycle %0d expected 3", at);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if ({bus.req, bus.addr, pcDbg} !== {1'b1, 32'h20, 32'h20}) begin
                fails++;
                $display("FAIL b_refetch%0d: req=%b addr=%h pc=%h expected 1 00000020 00000020",
                         k, bus.req, bus.addr, pcDbg);
            end
            waitRetire(20, at);
            tests++;
            if (at != 6 + 3 * k) begin
                fails++;
                $display("FAIL b_period%0d: retire cycle %0d expected %0d", k, at, 6 + 3 * k);
            end
        end
    endtask

    task automatic test_skip_and_halt();
        int at;
        logic reqSeen;
        clearMem();
        mem[0] = 32'hEA00_0006;   // B 0x20
        mem[8] = 32'h0AFF_FFFE;   // BEQ . (skipped)
        mem[9] = 32'hE7F0_00F0;   // undefined
        startCpu();
        waitRetire(20, at);
        waitRetire(20, at);
        tests++;
        if (at != 5) begin
            fails++;
            $display("FAIL skip_latency: retire cycle %0d expected 5", at);
        end
        tick();
        tests++;
        if ({bus.req, bus.addr} !== {1'b1, 32'h24}) begin
            fails++;
            $display("FAIL skip_next: req=%b addr=%h expected 1 00000024", bus.req, bus.addr);
        end
        tick();
        tick();
        tests++;
        if ({halted, bus.req, retire} !== 3'b100) begin
            fails++;
            $display("FAIL halt_enter: halted/req/retire=%b expected 100", {halted, bus.req, retire});
        end
        reqSeen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (bus.req !== 1'b0 || halted !== 1'b1 || retire !== 1'b0) reqSeen = 1'b1;
        end
        tests++;
        if (reqSeen !== 1'b0 || pcDbg !== 32'h24) begin
            fails++;
            $display("FAIL halt_sticky: activity=%b pc=%h expected 0 00000024", reqSeen, pcDbg);
        end
    endtask

    task automatic test_reset_mid_ldr();
        int at;
        int unsigned base;
        clearMem();
        mem[0] = 32'hE590_1008;   // LDR R1,[R0,#8]
        mem[2] = 32'hDEAD_BEEF;
        delayAddr   = 32'h8;
        delayCycles = 50;
        startCpu();
        repeat (5) tick();
        tests++;
        if ({bus.req, bus.we, bus.addr} !== {1'b1, 1'b0, 32'h8}) begin
            fails++;
            $display("FAIL mid_ldr_wait: req=%b we=%b addr=%h expected 1 0 00000008",
                     bus.req, bus.we, bus.addr);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        mem[0] = 32'hE580_1040;   // STR R1,[R0,#0x40]
        delayCycles = 0;
        @(negedge clk);
        tests++;
        if ({bus.req, bus.we, retire, halted, pcDbg} !== {4'b0000, 32'h0}) begin
            fails++;
            $display("FAIL rst_abort: req/we/retire/halted=%b pc=%h expected 0000 00000000",
                     {bus.req, bus.we, retire, halted}, pcDbg);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cycleNo = 0;
        base = writeCount;
        tick();
        tests++;
        if ({bus.req, bus.we, bus.addr, pcDbg} !== {1'b1, 1'b0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL rst_first_req: req=%b we=%b addr=%h pc=%h expected 1 0 00000000 00000000",
                     bus.req, bus.we, bus.addr, pcDbg);
        end
        waitRetire(20, at);
        tick();
        tests++;
        if (at != 4 || writeCount - base != 1 || wrDataLog[base[3:0]] !== 32'h0) begin
            fails++;
            $display("FAIL rst_no_wb: retire %0d writes=%0d data=%h expected 4 1 00000000",
                     at, writeCount - base, wrDataLog[base[3:0]]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        clearMem();
        test_reset();
        test_ldr_zero_wait();
        test_ldr_wait_states();
        test_dp();
        test_str();
        test_branch_loop();
        test_skip_and_halt();
        test_reset_mid_ldr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
